// File: rtl/image_load_scheduler.sv
// Periodic image loader: once per display period, waits for a VSYNC falling edge,
// streams 16 ROM rows of the current image into the line RAM, then advances the image.
module image_load_scheduler #(
  parameter int unsigned TICKS_PER_IMAGE = 6_250_000,
  parameter int unsigned ROM_LAT         = 1
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        vsync_n,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        write_en,
  output logic [3:0]  write_addr,
  output logic [15:0] write_data,
  output logic [3:0]  image_index,
  output logic        busy,
  output logic        load_done,
  output logic        overrun
);

  localparam int unsigned TW = $clog2(TICKS_PER_IMAGE);
  localparam int unsigned DW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TICKS_PER_IMAGE - 1);
  localparam logic [DW-1:0] DLAST = DW'(ROM_LAT - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_SYNC, ST_LOAD, ST_DRAIN} state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic                       r_vsync_q;
  logic [3:0]                 r_k;
  logic [DW-1:0]              r_drain;
  logic [TW-1:0]              r_timer;
  logic                       r_pending;
  logic                       r_overrun;
  logic [3:0]                 r_image;
  logic [7:0]                 r_rom_hold;
  logic [ROM_LAT-1:0]         r_vld;
  logic [ROM_LAT-1:0][3:0]    r_waddr;

  logic w_vs_fall;
  logic w_wrap;
  logic w_last_drain;
  logic w_busy;
  logic w_load_done;

  assign w_vs_fall    = r_vsync_q & ~vsync_n;
  assign w_wrap       = (r_state != ST_IDLE) && (r_timer == TMAX);
  assign w_last_drain = (r_drain == DLAST);

  // State register
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a wrap seen in WAIT starts SYNC at once so it is not lost
  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_next = ST_SYNC;
        ST_WAIT:  if (r_pending || w_wrap) w_next = ST_SYNC;
        ST_SYNC:  if (w_vs_fall) w_next = ST_LOAD;
        ST_LOAD:  if (r_k == 4'd15) w_next = ST_DRAIN;
        ST_DRAIN: if (w_last_drain) w_next = ST_WAIT;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    w_busy      = (r_state == ST_SYNC) || (r_state == ST_LOAD) || (r_state == ST_DRAIN);
    w_load_done = (r_state == ST_DRAIN) && w_last_drain && enable;
    rom_addr    = (r_state == ST_LOAD) ? {r_image, r_k} : r_rom_hold;
  end

  assign busy        = w_busy;
  assign load_done   = w_load_done;
  assign image_index = r_image;
  assign overrun     = r_overrun;
  assign write_en    = r_vld[ROM_LAT-1];
  assign write_addr  = r_waddr[ROM_LAT-1];
  assign write_data  = rom_data;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) r_vsync_q <= 1'b1;
    else        r_vsync_q <= vsync_n;
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k        <= '0;
      r_drain    <= '0;
      r_rom_hold <= '0;
      r_image    <= '0;
    end else begin
      r_k     <= (r_state == ST_LOAD && enable) ? r_k + 4'd1 : '0;
      r_drain <= (r_state == ST_DRAIN && enable && !w_last_drain) ? r_drain + DW'(1) : '0;
      if (r_state == ST_LOAD) r_rom_hold <= {r_image, r_k};
      if (w_load_done)        r_image    <= r_image + 4'd1;
    end
  end

  // Period timer; pending is consumed by the WAIT->SYNC move even on a wrap cycle
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer   <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else if (!enable) begin
      r_timer   <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (r_state != ST_IDLE) r_timer <= w_wrap ? '0 : r_timer + TW'(1);
      if (w_wrap && (r_pending || w_busy)) r_overrun <= 1'b1;
      if (r_state == ST_WAIT && w_next == ST_SYNC) r_pending <= 1'b0;
      else if (w_wrap)                             r_pending <= 1'b1;
    end
  end

  // Write pipeline matching the ROM latency
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= '0;
      r_waddr <= '0;
    end else if (!enable) begin
      r_vld <= '0;
    end else begin
      r_vld[0]   <= (r_state == ST_LOAD);
      r_waddr[0] <= r_k;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        r_vld[i]   <= r_vld[i-1];
        r_waddr[i] <= r_waddr[i-1];
      end
    end
  end

endmodule
